m1_mem_resp: RTL

Responder end of the M1 core's instruction and data memory interfaces: a single on-chip word memory that serves both the I-side and the D-side request/done handshakes. Simultaneous requests are arbitrated round-robin. Reads and byte-selected writes complete after a programmable number of wait states. It sits beside the core top-level and stands in for caches/external memory in simulation and small FPGA builds.

---
 rtl/m1_mem_resp_if.sv | 27 ++
 rtl/m1_mem_resp.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/m1_mem_resp_if.sv
// Request/done handshake bundle between the M1 core's I/D memory ports
// and the on-chip memory responder.
interface m1_mem_resp_if;
  logic        imem_read_i;
  logic [31:0] imem_addr_i;
  logic        imem_done_o;
  logic [31:0] imem_data_o;
  logic        dmem_read_i;
  logic        dmem_write_i;
  logic [3:0]  dmem_sel_i;
  logic [31:0] dmem_addr_i;
  logic [31:0] dmem_data_i;
  logic        dmem_done_o;
  logic [31:0] dmem_data_o;

  modport master (
    output imem_read_i, imem_addr_i,
    output dmem_read_i, dmem_write_i, dmem_sel_i, dmem_addr_i, dmem_data_i,
    input  imem_done_o, imem_data_o, dmem_done_o, dmem_data_o
  );

  modport slave (
    input  imem_read_i, imem_addr_i,
    input  dmem_read_i, dmem_write_i, dmem_sel_i, dmem_addr_i, dmem_data_i,
    output imem_done_o, imem_data_o, dmem_done_o, dmem_data_o
  );
endinterface

// File: rtl/m1_mem_resp.sv
// Shared word memory answering the M1 I-side and D-side handshakes with
// round-robin arbitration, byte-lane writes and a fixed wait-state count.
module m1_mem_resp #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic         sys_clock_i,
  input  logic         sys_reset_i,
  m1_mem_resp_if.slave s_mem
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_count;
  logic                  r_last_d;
  logic                  r_side_d;
  logic                  r_is_write;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [3:0]            r_sel;
  logic [31:0]           r_wdata;
  logic                  r_imem_done;
  logic                  r_dmem_done;
  logic [31:0]           r_imem_data;
  logic [31:0]           r_dmem_data;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_i_pend;
  logic                  w_d_pend;
  logic                  w_grant_d;
  logic                  w_fire;
  logic [ADDR_WIDTH-1:0] w_i_index;
  logic [ADDR_WIDTH-1:0] w_d_index;
  logic                  w_unused_addr;

  assign w_i_pend  = s_mem.imem_read_i;
  assign w_d_pend  = s_mem.dmem_read_i | s_mem.dmem_write_i;
  assign w_i_index = s_mem.imem_addr_i[ADDR_WIDTH+1:2];
  assign w_d_index = s_mem.dmem_addr_i[ADDR_WIDTH+1:2];
  assign w_fire    = (r_state == ST_ACCESS) && (r_count == 4'd0);

  // Byte offset and upper address bits alias onto the same word.
  assign w_unused_addr = ^{s_mem.imem_addr_i[31:ADDR_WIDTH+2], s_mem.imem_addr_i[1:0],
                           s_mem.dmem_addr_i[31:ADDR_WIDTH+2], s_mem.dmem_addr_i[1:0]};

  // Round-robin grant: on a tie the side not served last wins.
  always_comb begin
    w_grant_d = 1'b0;
    if (w_d_pend && !w_i_pend) begin
      w_grant_d = 1'b1;
    end else if (w_d_pend && w_i_pend) begin
      w_grant_d = ~r_last_d;
    end else begin
      w_grant_d = 1'b0;
    end
  end

  // Memory array: lane-masked write on the completing edge of a write.
  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_i && w_fire && r_is_write) begin
      for (int n = 0; n < 4; n++) begin
        if (r_sel[n]) begin
          r_mem[r_index][8*n +: 8] <= r_wdata[8*n +: 8];
        end
      end
    end
  end

  // Access sequencer with registered done pulses and read data.
  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      r_state     <= ST_IDLE;
      r_count     <= 4'd0;
      r_last_d    <= 1'b1;
      r_side_d    <= 1'b0;
      r_is_write  <= 1'b0;
      r_index     <= '0;
      r_sel       <= 4'b0000;
      r_wdata     <= 32'd0;
      r_imem_done <= 1'b0;
      r_dmem_done <= 1'b0;
      r_imem_data <= 32'd0;
      r_dmem_data <= 32'd0;
    end else begin
      r_imem_done <= 1'b0;
      r_dmem_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_i_pend || w_d_pend) begin
            r_side_d <= w_grant_d;
            r_last_d <= w_grant_d;
            r_count  <= WAIT_LOAD;
            r_state  <= ST_ACCESS;
            if (w_grant_d) begin
              r_index    <= w_d_index;
              r_is_write <= s_mem.dmem_write_i;
              r_sel      <= s_mem.dmem_sel_i;
              r_wdata    <= s_mem.dmem_data_i;
            end else begin
              r_index    <= w_i_index;
              r_is_write <= 1'b0;
              r_sel      <= 4'b0000;
              r_wdata    <= 32'd0;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
            r_state <= ST_ACCESS;
          end else begin
            // Writes also return the word as it was before the update.
            if (r_side_d) begin
              r_dmem_data <= r_mem[r_index];
              r_dmem_done <= 1'b1;
            end else begin
              r_imem_data <= r_mem[r_index];
              r_imem_done <= 1'b1;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_mem.imem_done_o = r_imem_done;
  assign s_mem.imem_data_o = r_imem_data;
  assign s_mem.dmem_done_o = r_dmem_done;
  assign s_mem.dmem_data_o = r_dmem_data;

endmodule
